uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to emit two stop bits per frame.
module uart_tx (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       DATA_VALID,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [6:0] prescale,
    output logic       TX_OUT,
    output logic       busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0] state;
    logic [6:0] cnt;
    logic [6:0] n_q;
    logic [2:0] idx;
    logic [7:0] data_q;
    logic       par_en_q;
    logic       par_typ_q;
    logic       bit_end;
    logic       par_bit;
`ifdef UART_TX_TWO_STOP_EN
    logic       stop2;
`endif

    // A latched prescale of 0 or 1 means every cycle ends a bit.
    assign bit_end = (n_q <= 7'd1) ? 1'b1 : (cnt == n_q - 7'd1);
    assign par_bit = (^data_q) ^ par_typ_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 7'd0;
            n_q       <= 7'd0;
            idx       <= 3'd0;
            data_q    <= 8'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2     <= 1'b0;
`endif
        end else begin
            if (state != IDLE)
                cnt <= bit_end ? 7'd0 : cnt + 7'd1;
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                    cnt    <= 7'd0;
                    idx    <= 3'd0;
`ifdef UART_TX_TWO_STOP_EN
                    stop2  <= 1'b0;
`endif
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        n_q       <= prescale;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        idx    <= 3'd0;
                        TX_OUT <= data_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            if (par_en_q) begin
                                state  <= PARITY;
                                TX_OUT <= par_bit;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            TX_OUT <= data_q[idx + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                        if (!stop2) begin
                            stop2 <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames plus randomized frames against
// a bit-list reference model of the serial line.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [6:0] prescale;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            chk("idle_tx", int'(TX_OUT), 1);
            chk("idle_busy", int'(busy), 0);
            step();
        end
    endtask

    // Expected line levels, one entry per bit period.
    task automatic build_bits(input logic [7:0] d, input logic pe,
                              input logic pt, output int bits[$]);
        bits = {};
        bits.push_back(0);
        for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
        if (pe) bits.push_back(int'((^d) ^ pt));
        for (int i = 0; i < STOPS; i++) bits.push_back(1);
    endtask

    // Called from an idle cycle; returns at the idle cycle after the frame.
    task automatic run_frame(input logic [7:0] d, input logic pe,
                             input logic pt, input logic [6:0] ps,
                             input bit hold, input int poke);
        int bits[$];
        int n, len, busy_cnt;
        n = (ps == 0) ? 1 : int'(ps);
        build_bits(d, pe, pt, bits);
        len = bits.size() * n;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps;
        DATA_VALID = 1'b1;
        chk("pre_busy", int'(busy), 0);
        step();
        if (!hold) DATA_VALID = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < len; c++) begin
            if (c == poke) begin
                DATA_VALID = 1'b1;
                P_DATA = 8'h3C; PAR_EN = ~pe; PAR_TYP = ~pt;
                prescale = 7'd3;
            end else if (c == poke + 1 && !hold) begin
                DATA_VALID = 1'b0;
            end
            chk("frame_tx", int'(TX_OUT), bits[c / n]);
            chk("frame_busy", int'(busy), 1);
            if (busy) busy_cnt++;
            step();
        end
        chk("busy_len", busy_cnt, (10 + int'(pe) + STOPS - 1) * n);
        chk("end_tx", int'(TX_OUT), 1);
        chk("end_busy", int'(busy), 0);
    endtask

    initial begin
        int bits[$];
        int plen;
        logic [7:0] rd;
        logic rpe, rpt;
        logic [6:0] rps;

        RST = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 7'd8;
        step();
        DATA_VALID = 1'b1;
        step();
        chk("rst_tx", int'(TX_OUT), 1);
        chk("rst_busy", int'(busy), 0);
        RST = 1'b0; DATA_VALID = 1'b0;
        step();
        idle(2);

        // Even parity, odd parity, no parity at prescale 8
        run_frame(8'hA5, 1'b1, 1'b0, 7'd8, 1'b0, -1);
        idle(2);
        run_frame(8'hA5, 1'b1, 1'b1, 7'd8, 1'b0, -1);
        idle(2);
        run_frame(8'hA5, 1'b0, 1'b0, 7'd8, 1'b0, -1);
        idle(2);

        // Mid-frame request with other data must be dropped
        run_frame(8'hA5, 1'b1, 1'b0, 7'd8, 1'b0, 30);
        idle(20);
        run_frame(8'h3C, 1'b0, 1'b1, 7'd2, 1'b0, -1);
        idle(2);

        // Reset during data bit 3, with a request held through it
        build_bits(8'hA5, 1'b1, 1'b0, bits);
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; prescale = 7'd8;
        DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        for (int c = 0; c < 4 * 8 + 3; c++) begin
            chk("pre_rst_tx", int'(TX_OUT), bits[c / 8]);
            step();
        end
        RST = 1'b1; DATA_VALID = 1'b1;
        step();
        chk("abort_tx", int'(TX_OUT), 1);
        chk("abort_busy", int'(busy), 0);
        RST = 1'b0; DATA_VALID = 1'b0;
        step();
        idle(3);
        run_frame(8'hA5, 1'b1, 1'b0, 7'd8, 1'b0, -1);
        idle(2);

        // Held request: back-to-back frames one idle cycle apart
        for (int f = 0; f < 3; f++)
            run_frame(8'hFF, 1'b0, 1'b0, 7'd1, 1'b1, -1);
        DATA_VALID = 1'b0;
        step();
        idle(3);

        // Prescale 0 behaves as 1
        run_frame(8'h5A, 1'b1, 1'b1, 7'd0, 1'b0, -1);
        idle(1);

        // Randomized frames with random mid-frame disturbances
        for (int r = 0; r < 8; r++) begin
            rd = 8'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            rps = 7'($urandom_range(0, 5));
            plen = int'($urandom_range(0, 8));
            run_frame(rd, rpe, rpt, rps, 1'b0, plen);
            idle(1 + int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
